simon_ctrl: RTL and testbench

SIMON_CTRL -- requirements
Module: simon_ctrl

---
 rtl/simon_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_simon_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_ctrl.sv
// simon_ctrl: memory-game sequencer. Counts down 3-2-1, grows a random colour
// sequence one element per round, plays it back on the LEDs, then checks the
// player's presses against it. It ends in WIN after MAXLEN rounds, or in FAIL
// on a wrong press or an input timeout.
module simon_ctrl #(
    parameter int MAXLEN        = 15,
    parameter int CD_TICKS      = 2,
    parameter int SHOW_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       Go,
    input  logic [3:0] btn,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [3:0] blank,
    output logic [3:0] led,
    output logic [3:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CD       = 3'd1,
        S_ADD      = 3'd2,
        S_SHOW_ON  = 3'd3,
        S_SHOW_OFF = 3'd4,
        S_INPUT    = 3'd5,
        S_FAIL     = 3'd6,
        S_WIN      = 3'd7
    } st_t;

    localparam logic [15:0] CD_T   = 16'(CD_TICKS);
    localparam logic [15:0] SHOW_T = 16'(SHOW_TICKS);
    localparam logic [15:0] TO_T   = 16'(TIMEOUT_TICKS);
    localparam logic [3:0]  MAX_L  = 4'(MAXLEN);

    st_t         st, nxt_st;
    logic [3:0]  len, nxt_len;
    logic [3:0]  idx, nxt_idx;
    logic [1:0]  digit, nxt_digit;
    logic [15:0] cnt, nxt_cnt;
    logic [7:0]  lfsr;
    logic [1:0]  mem [15];
    logic        mem_we;
    logic        last;
    logic        btn_ok;
    logic [1:0]  show_col;

    logic [3:0]  nxt_a, nxt_b, nxt_c, nxt_d, nxt_blank, nxt_led;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign state = {1'b0, st};

    // Next-state logic for the game FSM, counters and sequence write enable
    always_comb begin
        nxt_st    = st;
        nxt_len   = len;
        nxt_idx   = idx;
        nxt_digit = digit;
        nxt_cnt   = tick ? cnt + 16'd1 : cnt;
        mem_we    = 1'b0;
        last      = (idx == len - 4'd1);
        btn_ok    = (btn == onehot(mem[idx]));

        case (st)
            S_IDLE, S_FAIL, S_WIN: begin
                if (Go) begin
                    nxt_st    = S_CD;
                    nxt_len   = '0;
                    nxt_idx   = '0;
                    nxt_digit = 2'd3;
                end
            end
            S_CD: begin
                if (tick && (cnt + 16'd1 == CD_T)) begin
                    nxt_cnt = '0;
                    if (digit == 2'd1)
                        nxt_st = S_ADD;
                    else
                        nxt_digit = digit - 2'd1;
                end
            end
            S_ADD: begin
                mem_we  = 1'b1;
                nxt_len = len + 4'd1;
                nxt_idx = '0;
                nxt_st  = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick && (cnt + 16'd1 == SHOW_T))
                    nxt_st = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    if (last) begin
                        nxt_idx = '0;
                        nxt_st  = S_INPUT;
                    end else begin
                        nxt_idx = idx + 4'd1;
                        nxt_st  = S_SHOW_ON;
                    end
                end
            end
            S_INPUT: begin
                // A press outranks a timeout tick arriving on the same clk
                if (btn != 4'b0000) begin
                    if (!btn_ok)
                        nxt_st = S_FAIL;
                    else if (!last) begin
                        nxt_idx = idx + 4'd1;
                        nxt_cnt = '0;
                    end else if (len == MAX_L)
                        nxt_st = S_WIN;
                    else
                        nxt_st = S_ADD;
                end else if (tick && (cnt + 16'd1 == TO_T)) begin
                    nxt_st = S_FAIL;
                end
            end
            default: nxt_st = S_IDLE;
        endcase

        if (nxt_st != st)
            nxt_cnt = '0;
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the registered state
    always_comb begin
        nxt_a     = '0;
        nxt_b     = '0;
        nxt_c     = '0;
        nxt_d     = '0;
        nxt_blank = '1;
        nxt_led   = '0;
        // Entering SHOW_ON from ADD: the element being written this clk is forwarded
        show_col  = (mem_we && (nxt_idx == len)) ? lfsr[1:0] : mem[nxt_idx];

        case (nxt_st)
            S_CD: begin
                nxt_a     = {2'b00, nxt_digit};
                nxt_blank = 4'b0111;
            end
            S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT: begin
                nxt_d     = nxt_len;
                nxt_blank = 4'b1110;
                if (nxt_st == S_SHOW_ON)
                    nxt_led = onehot(show_col);
            end
            S_FAIL: begin
                nxt_a     = 4'hF;
                nxt_d     = nxt_len - 4'd1;
                nxt_blank = 4'b0110;
            end
            S_WIN: begin
                nxt_a     = 4'hC;
                nxt_d     = nxt_len;
                nxt_blank = 4'b0110;
            end
            default: ;
        endcase
    end

    // FSM state, counters, LFSR and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            digit <= 2'd3;
            cnt   <= '0;
            lfsr  <= 8'h01;
            A     <= '0;
            B     <= '0;
            C     <= '0;
            D     <= '0;
            blank <= '1;
            led   <= '0;
        end else begin
            st    <= nxt_st;
            len   <= nxt_len;
            idx   <= nxt_idx;
            digit <= nxt_digit;
            cnt   <= nxt_cnt;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            A     <= nxt_a;
            B     <= nxt_b;
            C     <= nxt_c;
            D     <= nxt_d;
            blank <= nxt_blank;
            led   <= nxt_led;
        end
    end

    // Sequence memory; every entry is written in ADD before it is read
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[len] <= lfsr[1:0];
    end

endmodule

// File: tb/tb_simon_ctrl.sv
// Directed-plus-random bench for simon_ctrl: tick spacing and input gaps are
// randomised, and expected colours come from a free-running LFSR model.
module tb_simon_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, Go;
    logic [3:0] btn;
    logic [3:0] A, B, C, D, blank, led, state;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr;
    logic [1:0] seq[$];

    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded 8'h01 by reset, steps every clk
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    simon_ctrl #(
        .MAXLEN(15),
        .CD_TICKS(2),
        .SHOW_TICKS(2),
        .TIMEOUT_TICKS(8)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .Go(Go), .btn(btn),
        .A(A), .B(B), .C(C), .D(D), .blank(blank), .led(led), .state(state)
    );

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) clk1();
    endtask

    task automatic start_game();
        seq.delete();
        Go = 1'b1;
        clk1();
        Go = 1'b0;
        chk("go_state", state, 4'd1);
        chk("go_A", A, 4'd3);
        chk("go_blank", blank, 4'b0111);
    endtask

    // Six ticks at two per digit; Go may be thrashed to show it is ignored
    task automatic countdown(input bit noise);
        for (int k = 1; k <= 6; k++) begin
            if (noise) Go = 1'($urandom_range(0, 1));
            gap();
            tick_pulse();
            Go = 1'b0;
            if (k < 6) begin
                chk("cd_state", state, 4'd1);
                chk("cd_A", A, 4'(3 - k / 2));
            end else begin
                chk("cd_to_add", state, 4'd2);
            end
        end
    endtask

    task automatic do_add();
        chk("add_state", state, 4'd2);
        chk("add_D", D, 4'(seq.size()));
        seq.push_back(m_lfsr[1:0]);
        clk1();
        chk("show_state", state, 4'd3);
        chk("show_D", D, 4'(seq.size()));
    endtask

    task automatic do_show(input bit junk);
        int unsigned L = seq.size();
        for (int i = 0; i < int'(L); i++) begin
            chk("show_led", led, oh(seq[i]));
            if (junk) begin
                btn = 4'b0011;
                clk1();
                btn = 4'b0000;
                chk("junk_state", state, 4'd3);
                chk("junk_led", led, oh(seq[i]));
            end
            gap();
            tick_pulse();
            gap();
            tick_pulse();
            chk("off_state", state, 4'd4);
            chk("off_led", led, 4'd0);
            gap();
            tick_pulse();
            chk("after_off", state, (i < int'(L) - 1) ? 4'd3 : 4'd5);
        end
    endtask

    task automatic do_input_all();
        int unsigned L = seq.size();
        for (int j = 0; j < int'(L); j++) begin
            gap();
            btn = oh(seq[j]);
            clk1();
            btn = 4'b0000;
            if (j < int'(L) - 1) chk("in_state", state, 4'd5);
            else chk("in_done", state, (L == 15) ? 4'd7 : 4'd2);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; Go = 1'b0; btn = 4'b0000;
        clk1();
        clk1();
        chk("rst_state", state, 4'd0);
        chk("rst_blank", blank, 4'b1111);
        chk("rst_led", led, 4'd0);
        chk("rst_A", A, 4'd0);
        chk("rst_D", D, 4'd0);
        reset = 1'b0;
        clk1();

        // Full game to WIN
        start_game();
        countdown(1'b1);
        for (int r = 1; r <= 15; r++) begin
            do_add();
            do_show(1'b0);
            do_input_all();
        end
        chk("win_A", A, 4'hC);
        chk("win_D", D, 4'hF);
        chk("win_blank", blank, 4'b0110);
        chk("win_led", led, 4'd0);

        // Restart from WIN; wrong colour on round 3, second press
        start_game();
        countdown(1'b0);
        for (int r = 1; r <= 2; r++) begin
            do_add();
            do_show(1'b0);
            do_input_all();
        end
        do_add();
        do_show(1'b0);
        btn = oh(seq[0]);
        clk1();
        chk("r3_p1", state, 4'd5);
        btn = oh(seq[1] + 2'd1);
        clk1();
        btn = 4'b0000;
        chk("wrong_state", state, 4'd6);
        chk("wrong_A", A, 4'hF);
        chk("wrong_D", D, 4'd2);
        chk("wrong_led", led, 4'd0);
        chk("wrong_blank", blank, 4'b0110);

        // Timeout: eight idle ticks in INPUT
        start_game();
        countdown(1'b0);
        do_add();
        do_show(1'b0);
        for (int t = 1; t <= 7; t++) begin
            gap();
            tick_pulse();
            chk("to_wait", state, 4'd5);
        end
        gap();
        tick_pulse();
        chk("to_state", state, 4'd6);
        chk("to_A", A, 4'hF);
        chk("to_D", D, 4'd0);

        // Press on the same clk as the eighth tick wins over the timeout
        start_game();
        countdown(1'b0);
        do_add();
        do_show(1'b0);
        for (int t = 1; t <= 7; t++) begin
            gap();
            tick_pulse();
        end
        chk("race_wait", state, 4'd5);
        tick = 1'b1;
        btn = oh(seq[0]);
        clk1();
        tick = 1'b0;
        btn = 4'b0000;
        chk("race_state", state, 4'd2);

        // Multi-hot press ignored in SHOW_ON, fatal in INPUT
        do_add();
        do_show(1'b1);
        btn = 4'b0011;
        clk1();
        btn = 4'b0000;
        chk("multi_state", state, 4'd6);
        chk("multi_D", D, 4'd1);

        // Reset mid-show, then a clean restart
        start_game();
        countdown(1'b0);
        do_add();
        gap();
        tick_pulse();
        chk("pre_rst", state, 4'd3);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        chk("mid_rst_state", state, 4'd0);
        chk("mid_rst_blank", blank, 4'b1111);
        chk("mid_rst_led", led, 4'd0);
        start_game();
        countdown(1'b0);
        do_add();
        do_show(1'b0);
        do_input_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
